caesar_stream_ctrl: RTL
=======================

Name: caesar_stream_ctrl

Overview:
Byte-stream controller between the UART receiver's byte output and the UART transmitter's byte input in the Caesar echo design. It parses in-band escape commands that configure the shift key and the encrypt/decrypt mode. It forwards all other bytes through a Caesar letter shift into a one-entry output register with a valid/ready handshake to the transmitter. It runs at 50 MHz.

Parameters:
KEY_DEFAULT, 3, shift key loaded at reset (0..25)
ESC_BYTE, 8'h1B, command escape character
TIMEOUT_CYCLES, 50_000_000, idle cycles after which an incomplete command is abandoned (1 s at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  reset, synchronous, active-low
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
rx_err  in  1  framing error, qualified by rx_valid
tx_ready  in  1  transmitter can accept a byte this cycle
tx_valid  out  1  tx_data holds a byte for transmission
tx_data  out  8  byte to transmit
key  out  5  current shift key, 0..25
decrypt  out  1  1 = shift by (26-key) mod 26
overrun  out  1  one-cycle pulse: a data byte was dropped

Behaviour:
- Clock is clk. Reset is synchronous and active-low on reset_n.
- Reset values: tx_valid=0, tx_data=0, key=KEY_DEFAULT, decrypt=0, overrun=0, FSM=IDLE, timeout counter=0.
- Reset mid-transfer discards the held byte and any partial command.
- Cipher: effective shift s = decrypt ? (26-key)%26 : key.
  - 'A'..'Z' maps to ((c-'A'+s)%26)+'A'.
  - 'a'..'z' is handled the same way with base 'a'.
  - All other bytes pass unchanged.
  - Modular add uses a 6-bit sum with one conditional subtract of 26.
- FSM states: IDLE, ESC, KEY. Transitions happen on rx_valid && !rx_err.
  - IDLE: a byte equal to ESC_BYTE goes to ESC. Any other byte is a data byte (cipher, then emit).
  - ESC:
    - 'K' goes to KEY.
    - 'E' sets decrypt=0, then IDLE.
    - 'D' sets decrypt=1, then IDLE.
    - ESC_BYTE emits literal ESC_BYTE unciphered, then IDLE.
    - Any other byte is discarded, then IDLE.
  - KEY:
    - 'A'..'Z' sets key=byte-'A', then IDLE.
    - 'a'..'z' sets key=byte-'a', then IDLE.
    - Any other byte is discarded and key is unchanged, then IDLE.
  - Key and mode changes take effect for the next byte received.
- rx_valid && rx_err: the byte is ignored and the FSM returns to IDLE. No output, no overrun pulse.
- Timeout:
  - In ESC or KEY, the counter increments every cycle without a valid rx byte and clears on every rx byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and nothing changes.
  - The counter is held at 0 in IDLE.
- Output handshake:
  - Latency is 1 cycle. A data byte arriving at cycle n gives tx_valid=1 with the ciphered tx_data at cycle n+1.
  - tx_data is stable while tx_valid=1 and !tx_ready.
  - A transfer occurs when tx_valid && tx_ready. tx_valid clears the next cycle unless a new byte is loaded.
  - Simultaneous transfer and new data byte: the new byte loads, tx_valid stays 1, nothing is lost.
  - New data byte while tx_valid=1 && !tx_ready: the new byte is dropped, the held byte is kept, and overrun pulses for 1 cycle. The FSM still advances normally.
  - Command bytes never touch the output register and never cause overrun.

Decomposition:
- Package caesar_pkg holds:
  - the FSM state enum (IDLE, ESC, KEY);
  - command character constants CMD_KEY='K', CMD_ENC='E', CMD_DEC='D';
  - ALPHA_LEN=26;
  - function is_upper/is_lower.
- One combinational sub-module, caesar_char_shift (byte in, 5-bit shift in, byte out), instantiated once.
- caesar_char_shift can be reused by the existing cipher datapath.

Test Plan:
- After reset, send 'a','Z','!' with tx_ready=1 -> tx_data 'd','C','!', each tx_valid one cycle after its rx_valid; key=3, decrypt=0.
- Send 1B,'K','B' then 'Z' -> key=1, no tx_valid for the three command bytes, then tx_data='A'.
- Send 1B,'D' then 'D' with key=3 -> decrypt=1, tx_data='A'. Then send 1B,'E','A' -> tx_data='D'.
- Send 1B,1B -> single tx_data=8'h1B. Send 1B,'Q' -> no output and state back to IDLE (next 'a' -> 'd').
- Hold tx_ready=0, send 'a','b' -> tx_data='d' held and overrun pulses on the 'b' cycle. Then tx_ready=1 -> one transfer of 'd' and tx_valid=0 next cycle. Also cover rx_valid coinciding with the accept cycle -> no overrun.
- With TIMEOUT_CYCLES=16: send 1B, idle 16 cycles, then 'K' -> emitted 'N' (key 3) and key unchanged. Also cover rx_err during KEY -> IDLE with key unchanged, and reset_n=0 during KEY -> key=3, tx_valid=0.

Source files
------------

// File: rtl/caesar_pkg.sv
// Shared definitions for the Caesar echo byte-stream controller.
//   state_e         : command parser states
//   CMD_KEY/ENC/DEC : command characters that follow the escape byte
//   ALPHA_LEN       : letters in the alphabet
//   is_upper/lower  : ASCII letter classification helpers
package caesar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEsc,
    StKey
  } state_e;

  localparam logic [7:0] CMD_KEY = 8'h4B;  // 'K'
  localparam logic [7:0] CMD_ENC = 8'h45;  // 'E'
  localparam logic [7:0] CMD_DEC = 8'h44;  // 'D'

  localparam int unsigned ALPHA_LEN = 26;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

endpackage

// File: rtl/caesar_stream_ctrl_if.sv
// Byte-stream bus between the UART receiver/transmitter and the controller.
//   rx_valid/rx_data/rx_err : received byte strobe, byte, framing error
//   tx_ready                : transmitter accepts a byte this cycle
//   tx_valid/tx_data        : byte offered to the transmitter
// master = UART side (drives rx_* and tx_ready), slave = controller.
interface caesar_stream_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;

  modport master (
    output rx_valid, rx_data, rx_err, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, rx_err, tx_ready,
    output tx_valid, tx_data
  );
endinterface

// File: rtl/caesar_char_shift.sv
// Combinational Caesar letter shift.
//   data   : input byte
//   shift  : shift amount, 0..25
//   result : letters rotated within their own case, other bytes unchanged
module caesar_char_shift
  import caesar_pkg::*;
(
  input  logic [7:0] data,
  input  logic [4:0] shift,
  output logic [7:0] result
);

  logic [7:0] base;
  logic [7:0] offset;
  logic [5:0] sum;

  always_comb begin
    base   = is_upper(data) ? 8'h41 : 8'h61;
    offset = data - base;
    // Offset and shift are both below 26, so one subtract brings the sum back into range.
    sum    = {1'b0, offset[4:0]} + {1'b0, shift};
    if (sum >= 6'(ALPHA_LEN)) begin
      sum = sum - 6'(ALPHA_LEN);
    end
    if (is_upper(data) || is_lower(data)) begin
      result = base + {2'b00, sum};
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/caesar_stream_ctrl.sv
// Caesar echo stream controller: parses escape commands (key / mode) from the
// received byte stream and forwards data bytes, shifted, to a one-entry output
// register handshaken to the transmitter.
//   clk, reset_n : clock and synchronous active-low reset
//   bus          : rx byte input and tx valid/ready output (slave side)
//   key          : current shift key, 0..25
//   decrypt      : 1 = shift by (26-key) mod 26
//   overrun      : one-cycle pulse when a data byte is dropped
module caesar_stream_ctrl
  import caesar_pkg::*;
#(
  parameter logic [4:0]  KEY_DEFAULT    = 5'd3,
  parameter logic [7:0]  ESC_BYTE       = 8'h1B,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  caesar_stream_ctrl_if.slave   bus,
  output logic [4:0]            key,
  output logic                  decrypt,
  output logic                  overrun
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state;
  logic [CntW-1:0] idle_cnt;
  logic            tx_valid_q;
  logic [7:0]      tx_data_q;

  logic       rx_good;
  logic [4:0] eff_shift;
  logic [7:0] shifted;
  logic       emit;
  logic [7:0] emit_byte;
  logic       can_load;
  logic [7:0] key_upper;
  logic [7:0] key_lower;

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

  always_comb begin
    rx_good   = bus.rx_valid && !bus.rx_err;
    eff_shift = (decrypt && (key != 5'd0)) ? (5'(ALPHA_LEN) - key) : key;
    // A doubled escape is emitted as a literal, bypassing the cipher.
    emit      = rx_good && (((state == StIdle) && (bus.rx_data != ESC_BYTE)) ||
                            ((state == StEsc) && (bus.rx_data == ESC_BYTE)));
    emit_byte = (state == StEsc) ? ESC_BYTE : shifted;
    can_load  = !tx_valid_q || bus.tx_ready;
    key_upper = bus.rx_data - 8'h41;
    key_lower = bus.rx_data - 8'h61;
  end

  caesar_char_shift u_shift (
    .data   (bus.rx_data),
    .shift  (eff_shift),
    .result (shifted)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= StIdle;
      idle_cnt   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      key        <= KEY_DEFAULT;
      decrypt    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // Output register: load wins over clear, a blocked load is dropped.
      if (emit) begin
        if (can_load) begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= emit_byte;
        end else begin
          overrun <= 1'b1;
        end
      end else if (tx_valid_q && bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      if (bus.rx_valid) begin
        idle_cnt <= '0;
        if (bus.rx_err) begin
          state <= StIdle;
        end else begin
          case (state)
            StIdle: begin
              if (bus.rx_data == ESC_BYTE) state <= StEsc;
            end
            StEsc: begin
              state <= StIdle;
              if (bus.rx_data == CMD_KEY) begin
                state <= StKey;
              end else if (bus.rx_data == CMD_ENC) begin
                decrypt <= 1'b0;
              end else if (bus.rx_data == CMD_DEC) begin
                decrypt <= 1'b1;
              end
            end
            StKey: begin
              state <= StIdle;
              if (is_upper(bus.rx_data)) begin
                key <= key_upper[4:0];
              end else if (is_lower(bus.rx_data)) begin
                key <= key_lower[4:0];
              end
            end
            default: state <= StIdle;
          endcase
        end
      end else if (state != StIdle) begin
        // Abandon a half-entered command after a long silence.
        if (idle_cnt == CntLast) begin
          state    <= StIdle;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
